// File: rtl/collision_scanner.sv
// Time-multiplexed AABB collision checker: snapshots player + N_OBJ obstacles on start,
// tests one obstacle per clock, then reports hit mask, lowest hit index and a crash counter.
module collision_scanner #(
  parameter int N_OBJ = 4,
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int DW    = 6,
  parameter int CNT_W = 8,
  localparam int IW   = $clog2(N_OBJ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                start,
  input  logic [DW-1:0]       box_w,
  input  logic [DW-1:0]       box_h,
  input  logic [XW-1:0]       player_x,
  input  logic [YW-1:0]       player_y,
  input  logic [N_OBJ*XW-1:0] obj_x,
  input  logic [N_OBJ*YW-1:0] obj_y,
  input  logic [N_OBJ-1:0]    obj_en,
  output logic                busy,
  output logic                done,
  output logic                hit,
  output logic [N_OBJ-1:0]    hit_mask,
  output logic [IW-1:0]       hit_idx,
  output logic [CNT_W-1:0]    crash_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} state_t;

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_idx;
  logic [N_OBJ-1:0]  r_mask;
  logic              r_busy, r_done, r_hit;
  logic [N_OBJ-1:0]  r_hit_mask;
  logic [IW-1:0]     r_hit_idx;
  logic [CNT_W-1:0]  r_crash;

  logic [XW-1:0]     r_px;
  logic [YW-1:0]     r_py;
  logic [DW-1:0]     r_w, r_h;
  logic [XW-1:0]     r_ox [N_OBJ];
  logic [YW-1:0]     r_oy [N_OBJ];
  logic [N_OBJ-1:0]  r_en;

  logic              w_last, w_hit, w_accept;
  logic [IW-1:0]     w_low_idx;
  logic              w_found;
  logic [XW:0]       w_px_lo, w_px_hi, w_ox_lo, w_ox_hi;
  logic [YW:0]       w_py_lo, w_py_hi, w_oy_lo, w_oy_hi;

  assign w_last   = (r_idx == IW'(N_OBJ - 1));
  assign w_accept = (r_state == S_IDLE) && start && !clear;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start)  w_state_nxt = S_SCAN;
      S_SCAN:   if (w_last) w_state_nxt = S_REPORT;
      S_REPORT:             w_state_nxt = S_IDLE;
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_state <= S_IDLE;
    else if (clear) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Sums are formed one bit wider than the operands so edge cases near full scale never wrap.
  always_comb begin
    w_px_lo = {1'b0, r_px};
    w_px_hi = {1'b0, r_px} + (XW+1)'(r_w);
    w_ox_lo = {1'b0, r_ox[r_idx]};
    w_ox_hi = {1'b0, r_ox[r_idx]} + (XW+1)'(r_w);
    w_py_lo = {1'b0, r_py};
    w_py_hi = {1'b0, r_py} + (YW+1)'(r_h);
    w_oy_lo = {1'b0, r_oy[r_idx]};
    w_oy_hi = {1'b0, r_oy[r_idx]} + (YW+1)'(r_h);
    w_hit   = r_en[r_idx] && (w_px_lo < w_ox_hi) && (w_px_hi > w_ox_lo)
                          && (w_py_lo < w_oy_hi) && (w_py_hi > w_oy_lo);
  end

  always_comb begin
    w_low_idx = '0;
    w_found   = 1'b0;
    for (int unsigned k = 0; k < N_OBJ; k++) begin
      if (r_mask[k] && !w_found) begin
        w_low_idx = IW'(k);
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_px <= player_x;
      r_py <= player_y;
      r_w  <= box_w;
      r_h  <= box_h;
      r_en <= obj_en;
      for (int unsigned k = 0; k < N_OBJ; k++) begin
        r_ox[k] <= obj_x[k*XW +: XW];
        r_oy[k] <= obj_y[k*YW +: YW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0; r_mask <= '0; r_busy <= 1'b0; r_done <= 1'b0;
      r_hit <= 1'b0; r_hit_mask <= '0; r_hit_idx <= '0; r_crash <= '0;
    end else if (clear) begin
      r_idx <= '0; r_mask <= '0; r_busy <= 1'b0; r_done <= 1'b0;
      r_hit <= 1'b0; r_hit_mask <= '0; r_hit_idx <= '0; r_crash <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_mask <= '0;
          r_idx  <= '0;
          r_busy <= 1'b1;
        end
        S_SCAN: begin
          r_mask[r_idx] <= w_hit;
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        S_REPORT: begin
          r_hit_mask <= r_mask;
          r_hit      <= |r_mask;
          r_hit_idx  <= w_low_idx;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          if (|r_mask && r_crash != '1) r_crash <= r_crash + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign hit       = r_hit;
  assign hit_mask  = r_hit_mask;
  assign hit_idx   = r_hit_idx;
  assign crash_cnt = r_crash;

endmodule
